// File: rtl/spi_disp_init_seq.sv
// Display bring-up sequencer: pulses the panel reset, plays a ROM script of command/data/delay
// entries into the SPI byte shifter, then passes the shifter through to the host stream.
module spi_disp_init_seq #(
    parameter int RST_CYCLES = 1000,
    parameter int DELAY_UNIT = 100,
    parameter int ROM_AW     = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_dc,
    output logic [7:0]        tx_data,
    input  logic              host_valid,
    input  logic              host_dc,
    input  logic [7:0]        host_data,
    output logic              host_ready,
    output logic              reset_display,
    output logic              busy,
    output logic              init_done,
    output logic              err
);

    localparam int CW0 = $clog2(RST_CYCLES + 1);
    localparam int CW1 = $clog2(255 * DELAY_UNIT + 1);
    localparam int CWM = (CW0 > CW1) ? CW0 : CW1;
    localparam int CW  = (CWM > 18) ? CWM : 18;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST_LO = 3'd1;
    localparam logic [2:0] S_RST_HI = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_DECODE = 3'd4;
    localparam logic [2:0] S_SEND   = 3'd5;
    localparam logic [2:0] S_DELAY  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [1:0] OP_CMD  = 2'b00;
    localparam logic [1:0] OP_DATA = 2'b01;
    localparam logic [1:0] OP_DLY  = 2'b10;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic              txv_q, txv_d;
    logic              txdc_q, txdc_d;
    logic [7:0]        txdata_q, txdata_d;
    logic              err_q, err_d;
    logic              advance;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        txv_d    = txv_q;
        txdc_d   = txdc_q;
        txdata_d = txdata_q;
        err_d    = err_q;
        advance  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RST_LO;
                    cnt_d   = CW'(RST_CYCLES - 1);
                    err_d   = 1'b0;
                end
            end
            S_RST_LO: begin
                if (cnt_q == '0) begin
                    state_d = S_RST_HI;
                    cnt_d   = CW'(RST_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RST_HI: begin
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data[9:8] == OP_CMD || rom_data[9:8] == OP_DATA) begin
                    state_d  = S_SEND;
                    txv_d    = 1'b1;
                    txdc_d   = rom_data[8];
                    txdata_d = rom_data[7:0];
                end else if (rom_data[9:8] == OP_DLY) begin
                    // Zero-length delay advances straight away instead of visiting DELAY
                    if (rom_data[7:0] == 8'h00) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = CW'(rom_data[7:0]) * CW'(DELAY_UNIT) - CW'(1);
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    txv_d    = 1'b0;
                    txdc_d   = 1'b0;
                    txdata_d = '0;
                    advance  = 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Running off the end of the ROM without END aborts the script
        if (advance) begin
            if (addr_q == '1) begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                addr_d  = addr_q + ROM_AW'(1);
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            txv_q    <= 1'b0;
            txdc_q   <= 1'b0;
            txdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            txv_q    <= txv_d;
            txdc_q   <= txdc_d;
            txdata_q <= txdata_d;
            err_q    <= err_d;
        end
    end

    logic in_done;
    assign in_done       = (state_q == S_DONE);
    assign rom_addr      = addr_q;
    assign tx_valid      = in_done ? host_valid : txv_q;
    assign tx_dc         = in_done ? host_dc    : txdc_q;
    assign tx_data       = in_done ? host_data  : txdata_q;
    assign host_ready    = in_done & tx_ready;
    assign reset_display = (state_q != S_RST_LO);
    assign busy          = (state_q != S_IDLE) && !in_done;
    assign init_done     = in_done;
    assign err           = err_q;

endmodule

// File: tb/tb_spi_disp_init_seq.sv
// Directed bench for spi_disp_init_seq with a small synchronous ROM model and a handshake scoreboard.
module tb_spi_disp_init_seq;

    localparam int RST_C = 10;
    localparam int DU    = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [9:0]    rom_data;
    logic          tx_valid, tx_ready, tx_dc;
    logic [7:0]    tx_data;
    logic          host_valid, host_dc, host_ready;
    logic [7:0]    host_data;
    logic          reset_display, busy, init_done, err;

    logic [9:0]    rom [4];
    logic [8:0]    exp_q [$];
    int            tests = 0;
    int            fails = 0;
    int            hs_cnt = 0;

    spi_disp_init_seq #(.RST_CYCLES(RST_C), .DELAY_UNIT(DU), .ROM_AW(AW)) dut (
        .CLK(clk), .RESET(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dc(tx_dc), .tx_data(tx_data),
        .host_valid(host_valid), .host_dc(host_dc), .host_data(host_data), .host_ready(host_ready),
        .reset_display(reset_display), .busy(busy), .init_done(init_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted byte must match the oldest expected {dc,data}
    always @(posedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_handshake: observed %0h expected none", {tx_dc, tx_data});
            end else begin
                check("handshake_byte", {23'd0, tx_dc, tx_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start_and_measure(output int lo, output int hi, output bit bad);
        bad = 1'b0;
        pulse_start();
        lo = 0;
        while (!reset_display && lo < 200) begin
            if (!busy) bad = 1'b1;
            lo++;
            @(negedge clk);
        end
        hi = 0;
        while (!tx_valid && hi < 200) begin
            if (!reset_display || !busy || rom_addr != '0) bad = 1'b1;
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!init_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", {31'd0, init_done}, 32'd1);
    endtask

    task automatic run_to_tx(output int n);
        pulse_start();
        n = 1;
        while (!tx_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, n, t0, t1, hs0;
        bit bad;
        rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
        host_valid = 1'b0; host_dc = 1'b0; host_data = 8'h00;
        rom[0] = 10'h000; rom[1] = 10'h000; rom[2] = 10'h000; rom[3] = 10'h000;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {19'd0, tx_valid, tx_dc, tx_data, rom_addr, host_ready},
              {19'd0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0});
        check("reset_status", {28'd0, reset_display, busy, init_done, err}, {28'd0, 4'b1000});
        rst = 1'b0;
        @(negedge clk);

        // Reset pulse timing and basic script
        rom[0] = {2'b00, 8'h2A}; rom[1] = {2'b01, 8'h05}; rom[2] = {2'b11, 8'h00}; rom[3] = {2'b11, 8'h00};
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h05});
        start_and_measure(lo, hi, bad);
        check("rst_lo_cycles", lo, RST_C);
        check("rst_hi_to_tx_cycles", hi, RST_C + 2);
        check("busy_addr_during_reset", {31'd0, bad}, 32'd0);
        wait_done();
        check("after_end_status", {29'd0, busy, init_done, err}, {29'd0, 3'b010});
        check("script_drained", exp_q.size(), 0);
        check("script_hs_count", hs_cnt, 2);

        // Host pass-through in DONE
        host_valid = 1'b1; host_dc = 1'b1; host_data = 8'h77; tx_ready = 1'b0;
        exp_q.push_back({1'b1, 8'h77});
        #1;
        check("host_mux", {22'd0, tx_valid, tx_dc, tx_data, host_ready}, {22'd0, 1'b1, 1'b1, 8'h77, 1'b0});
        tx_ready = 1'b1;
        #1;
        check("host_ready_follows", {31'd0, host_ready}, 32'd1);
        @(negedge clk);
        host_valid = 1'b0;
        check("host_byte_taken", exp_q.size(), 0);

        // Restart from DONE, stall first byte for 7 cycles, ignored start while busy
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, 8'h05});
        hs0 = hs_cnt;
        pulse_start();
        check("restart_status", {29'd0, init_done, host_ready, busy}, {29'd0, 3'b001});
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 7; i++) begin
            check("stall_stable", {23'd0, tx_valid, tx_dc, tx_data}, {23'd0, 1'b1, 1'b0, 8'h2A});
            start = (i == 3);
            @(negedge clk);
        end
        start = 1'b0;
        tx_ready = 1'b1;
        wait_done();
        check("stall_hs_count", hs_cnt - hs0, 2);
        check("stall_drained", exp_q.size(), 0);

        // Delay entry: arg 0 vs arg 3
        rom[0] = {2'b10, 8'h00}; rom[1] = {2'b00, 8'hAF}; rom[2] = {2'b11, 8'h00};
        exp_q.push_back({1'b0, 8'hAF});
        run_to_tx(t0);
        check("delay0_latency", t0, 2 * RST_C + 5);
        wait_done();
        rom[0] = {2'b10, 8'h03};
        exp_q.push_back({1'b0, 8'hAF});
        run_to_tx(t1);
        check("delay3_extra", t1 - t0, 3 * DU);
        wait_done();
        check("delay_drained", exp_q.size(), 0);

        // No END: address wrap sets err
        rom[0] = {2'b00, 8'h11}; rom[1] = {2'b00, 8'h22}; rom[2] = {2'b00, 8'h33}; rom[3] = {2'b00, 8'h44};
        exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b0, 8'h44});
        hs0 = hs_cnt;
        pulse_start();
        n = 0;
        while (!err && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wrap_status", {29'd0, err, busy, init_done}, {29'd0, 3'b100});
        check("wrap_hs_count", hs_cnt - hs0, 4);
        check("wrap_drained", exp_q.size(), 0);

        // New start clears err; then RESET mid-SEND
        exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
        pulse_start();
        check("err_cleared", {30'd0, err, busy}, {30'd0, 2'b01});
        n = 0;
        while (rom_addr != 2'd2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        tx_ready = 1'b0;
        n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_before_reset", {23'd0, tx_valid, tx_dc, tx_data}, {23'd0, 1'b1, 1'b0, 8'h33});
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {27'd0, tx_valid, busy, rom_addr, reset_display}, {27'd0, 5'b00001});
        check("async_reset_status", {30'd0, init_done, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        check("reset_drained", exp_q.size(), 0);
        exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b0, 8'h33}); exp_q.push_back({1'b0, 8'h44});
        start_and_measure(lo, hi, bad);
        check("rerun_rst_lo", lo, RST_C);
        check("rerun_rst_hi", hi, RST_C + 2);
        n = 0;
        while (!err && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("rerun_err", {31'd0, err}, 32'd1);
        check("rerun_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_disp_init_seq.md
Name: spi_disp_init_seq

Overview:
- Sequencer that owns the byte-level SPI transmitter feeding the display.
- After a start request it pulses the display hardware reset and plays an initialisation script from an external ROM: command bytes, data bytes and delays.
- It then hands the transmitter to a host pixel/command stream.
- Sits between the top-level key/LED logic and the SPI byte shifter that drives cs/sck/mosi/dc.

Parameters:
- RST_CYCLES, 1000, cycles reset_display is held low, and again cycles waited after release
- DELAY_UNIT, 100, clock cycles per delay tick in a ROM delay entry
- ROM_AW, 6, ROM address width (script length up to 2**ROM_AW entries)

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to (re)initialise the display
- rom_addr  out  ROM_AW  script ROM address
- rom_data  in  10  ROM word; synchronous ROM, valid 1 cycle after rom_addr
- tx_valid  out  1  byte request to SPI shifter
- tx_ready  in  1  shifter accepts byte when tx_valid&tx_ready
- tx_dc  out  1  dc level for the byte (0 = command, 1 = data)
- tx_data  out  8  byte to shift
- host_valid  in  1  host byte request
- host_dc  in  1  host dc
- host_data  in  8  host byte
- host_ready  out  1  host handshake
- reset_display  out  1  display reset, active-low
- busy  out  1  high from accepted start until init_done
- init_done  out  1  script finished; host owns transmitter
- err  out  1  sticky; ROM address wrapped without an END entry

Behaviour:
- ROM word format: [9:8] opcode, [7:0] arg.
  - 00: command byte (tx_dc=0)
  - 01: data byte (tx_dc=1)
  - 10: delay, arg*DELAY_UNIT cycles; arg=0 means no wait
  - 11: END
- Reset values: tx_valid=0, tx_dc=0, tx_data=0, rom_addr=0, host_ready=0, reset_display=1, busy=0, init_done=0, err=0; state IDLE.
- IDLE: all outputs idle. On start go to RST_LO, busy=1, counter cleared.
- RST_LO: reset_display=0 for exactly RST_CYCLES cycles, then RST_HI.
- RST_HI: reset_display=1 and wait RST_CYCLES cycles. Then rom_addr=0 and go to FETCH.
- FETCH: one cycle of ROM latency, then DECODE.
- DECODE (registers rom_data):
  - 00/01: load tx_data/tx_dc and assert tx_valid next cycle (state SEND).
  - 10: go to DELAY.
  - 11: go to DONE.
- SEND: tx_valid, tx_data and tx_dc are held stable until tx_ready. In the handshake cycle, tx_valid drops and rom_addr is incremented; next state FETCH. tx_valid never deasserts without a handshake.
- DELAY: count arg*DELAY_UNIT cycles (18-bit counter minimum), then increment rom_addr and go to FETCH.
- Address wrap: if rom_addr would increment past 2**ROM_AW-1, set err=1, deassert busy, return to IDLE. init_done stays 0.
- DONE: busy=0, init_done=1. Transmitter is muxed to the host: tx_valid=host_valid, tx_dc=host_dc, tx_data=host_data, host_ready=tx_ready (combinational pass-through).
- Per-byte throughput during the script: one byte per (handshake + 2) cycles minimum (FETCH + DECODE).
- start in any state other than IDLE or DONE: ignored.
- start in DONE: init_done=0 and host_ready=0 from the next cycle, then RST_LO. A host byte handshaking in the same cycle as start completes; no later host byte is accepted.
- RESET asserted mid-operation: every output returns to its reset value immediately (asynchronous), including tx_valid. A byte in flight in the shifter is abandoned. reset_display=1 during RESET.
- err is cleared only by RESET or by a newly accepted start.

Test Plan:
- RST_CYCLES=10: start pulse -> reset_display low exactly 10 cycles, high 10 cycles, then rom_addr=0 and busy=1 throughout.
- Script {00_2A, 01_05, 11_xx}, tx_ready always 1 -> handshakes (dc=0, 0x2A), then (dc=1, 0x05); init_done=1 and busy=0 after END; host_ready follows tx_ready.
- Same script with tx_ready held 0 for 7 cycles on the first byte -> tx_valid/tx_data/tx_dc stable for all 7 cycles; exactly one handshake per ROM entry.
- Script {10_03, 00_AF, 11}, DELAY_UNIT=4 -> 12-cycle gap before tx_valid for 0xAF; delay arg 00 -> no gap beyond FETCH/DECODE.
- ROM_AW=2, script with no END (all 00_xx) -> 4 bytes sent, then err=1, busy=0, init_done=0; a new start clears err.
- RESET asserted during SEND with tx_valid=1 -> tx_valid, busy and rom_addr at reset values in the same cycle; a following start re-runs the full sequence from RST_LO.
